fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
//
// PURPOSE
//   Sequences instruction fetch from the byte-addressed instruction memory.
//   - Issues word-aligned read requests, PC+4 per request.
//   - Tracks in-flight reads; buffers returned words in a prefetch FIFO.
//   - Presents instruction and PC to the pipelined decode stage with a valid/ready handshake.
//   - Sits between the PC/branch logic and instruction memory; owns the fetch PC.
//
// PARAMETERS
//   ADDRESS_WIDTH  32  Width of fetch addresses and PCs.
//   INSTR_WIDTH    32  Instruction word width.
//   FIFO_DEPTH     2   Prefetch entries. Power of 2, >=2; also the max in-flight requests.
//   RESET_PC       0   Fetch PC loaded on reset (ADDRESS_WIDTH bits).
//
// PORTS
//   clk              in   1              Clock, rising edge.
//   rst              in   1              Asynchronous, active-high reset.
//   redirect         in   1              Branch/jump taken: flush and refetch.
//   redirect_target  in   ADDRESS_WIDTH  New PC when redirect=1.
//   mem_req          out  1              Read request to instruction memory.
//   mem_addr         out  ADDRESS_WIDTH  Request address, bits[1:0]=0.
//   mem_gnt          in   1              Memory accepts request this cycle.
//   mem_rvalid       in   1              Read data valid; responses return in request order.
//   mem_rdata        in   INSTR_WIDTH    Read data.
//   instr_valid      out  1              FIFO head valid.
//   instr            out  INSTR_WIDTH    FIFO head instruction.
//   instr_pc         out  ADDRESS_WIDTH  PC of FIFO head.
//   instr_ready      in   1              Decode consumes head (pop when valid & ready).
//   fetch_fault      out  1              Misaligned redirect (ALIGN_CHECK_EN only, else tied 0).
//
// BEHAVIOUR
//   - Reset: fetch_pc=resp_pc=RESET_PC; FIFO empty; outstanding=drop_cnt=0; state RUN.
//     mem_req=0, instr_valid=0, fetch_fault=0 while rst high.
//   - States:
//       RUN   -> normal fetch.
//       FAULT -> no requests issued; entered only via ALIGN_CHECK_EN.
//   - Request: mem_req = RUN & !redirect & (fifo_count + outstanding < FIFO_DEPTH).
//     mem_addr = fetch_pc.
//     On mem_req & mem_gnt: fetch_pc += 4 (wraps modulo 2^ADDRESS_WIDTH); outstanding++.
//     mem_addr is held stable while mem_req & !mem_gnt.
//   - Response (mem_rvalid):
//       - If drop_cnt>0: drop_cnt--, data discarded.
//       - Else: push {resp_pc, mem_rdata} into the FIFO; resp_pc += 4.
//       - Either way, outstanding--.
//       - rvalid with outstanding=0 is ignored (post-reset stragglers).
//   - Output: instr/instr_pc driven from registered FIFO head; instr_valid = !empty.
//     - Head is held stable while valid & !ready.
//     - Zero-cycle bypass is not allowed: a push is visible the next cycle.
//   - Same-cycle events:
//     - Push and pop: both occur. The credit rule guarantees no overflow.
//     - Grant and rvalid: outstanding is unchanged.
//   - Redirect (highest priority, same cycle):
//     - FIFO cleared, pop ignored.
//     - drop_cnt += outstanding; this includes a response arriving this cycle, which is discarded.
//     - fetch_pc = resp_pc = redirect_target; mem_req forced 0.
//     - instr_valid=0 from the next cycle.
//     - First new request is issued the cycle after redirect.
//   - Latency: redirect -> mem_req 1 cycle; rvalid -> instr_valid 1 cycle.
//   - Counter widths: outstanding and drop_cnt are $clog2(FIFO_DEPTH+1) bits.
//     Their sum never exceeds FIFO_DEPTH.
//   - Reset mid-operation clears all state immediately. In-flight responses are dropped by the outstanding=0 rule.
//
// CONFIGURATION
//   ALIGN_CHECK_EN defined:
//     - A redirect with redirect_target[1:0]!=0 enters FAULT, sets fetch_fault=1 and flushes as above.
//     - FAULT issues no requests. In-flight responses are still drained and dropped.
//     - An aligned redirect returns to RUN and clears fetch_fault.
//   ALIGN_CHECK_EN undefined:
//     - redirect_target[1:0] is forced to 0. FAULT is never entered; fetch_fault tied 0.
//
// TESTING
//   1. Reset, gnt=1, rvalid 1 cycle after grant, ready=1
//      -> instr_pc sequence 0,4,8,C; a new instruction every cycle after a 2-cycle fill.
//   2. ready=0 for 10 cycles
//      -> exactly FIFO_DEPTH requests outstanding+buffered; mem_req=0; head PC 0 held stable.
//   3. gnt=0 for 3 cycles with mem_req=1
//      -> mem_addr stable at 0x10; PC advances only after gnt.
//   4. Redirect to 0x100 with 2 in flight
//      -> both responses dropped; next instr_pc=0x100; no stale instruction on instr.
//   5. Simultaneous rvalid+redirect+ready
//      -> arriving word dropped, FIFO empty next cycle, mem_addr=target next cycle.
//   6. ALIGN_CHECK_EN: redirect to 0x102
//      -> fetch_fault=1, mem_req=0; then redirect to 0x200 -> fault clears, fetch from 0x200.

Source files
------------

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Sequences instruction fetch from a byte-addressed instruction memory. It owns
// the fetch PC, issues word-aligned read requests (PC+4 per request), tracks
// in-flight reads, and buffers returned words in a small prefetch FIFO. The FIFO
// head is presented to decode through a valid/ready handshake.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   redirect          branch/jump taken: flush and refetch from redirect_target
//   redirect_target   new PC when redirect=1
//   mem_req/mem_addr  read request and word-aligned request address
//   mem_gnt           memory accepts the request this cycle
//   mem_rvalid/rdata  read response, returned in request order
//   instr_valid       FIFO head valid
//   instr/instr_pc    FIFO head instruction and its PC
//   instr_ready       decode consumes the head (pop on valid & ready)
//   fetch_fault       misaligned redirect seen (ALIGN_CHECK_EN builds only)
//
// Configuration
//   ALIGN_CHECK_EN    when defined, a redirect to a target with bits [1:0] != 0
//                     enters FAULT and raises fetch_fault until an aligned
//                     redirect arrives. When undefined the low target bits are
//                     ignored and fetch_fault stays 0.
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         INSTR_WIDTH   = 32,
    parameter int                         FIFO_DEPTH    = 2,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [INSTR_WIDTH-1:0]   mem_rdata,
    output logic                     instr_valid,
    output logic [INSTR_WIDTH-1:0]   instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    input  logic                     instr_ready,
    output logic                     fetch_fault
);

    localparam int                       CW          = $clog2(FIFO_DEPTH + 1);
    localparam int                       PW          = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]              DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP     = ADDRESS_WIDTH'(4);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t                   state;
    logic                     fault_q;
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] resp_pc;

    // outstanding counts every read in flight, including ones already marked
    // for dropping; drop_cnt is the subset of those still to be discarded.
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            drop_cnt;
    logic [CW-1:0]            fifo_count;
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;

    logic [INSTR_WIDTH-1:0]   instr_mem [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem    [FIFO_DEPTH];

    logic [ADDRESS_WIDTH-1:0] target;
    logic                     misaligned;
    logic [CW:0]              credit_used;
    logic                     grant;
    logic                     resp_accept;
    logic                     push;
    logic                     pop;

    // Fetch addresses are always word aligned, whatever the target's low bits.
    assign target = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};

`ifdef ALIGN_CHECK_EN
    assign misaligned = (redirect_target[1:0] != 2'b00);
`else
    logic target_low_unused;
    assign target_low_unused = ^redirect_target[1:0];
    assign misaligned        = 1'b0;
`endif

    // A new request needs a FIFO slot reserved for its response, so buffered
    // plus in-flight words never exceed the FIFO depth.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign mem_req     = !rst && (state == RUN) && !redirect && (credit_used < DEPTH_LIMIT);
    assign mem_addr    = fetch_pc;
    assign grant       = mem_req && mem_gnt;

    // Responses with nothing in flight are leftovers from before a reset.
    assign resp_accept = mem_rvalid && (outstanding != '0);
    assign push        = resp_accept && (drop_cnt == '0) && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign fetch_fault = fault_q;

    // NOTE: sequential state is assigned with <= so every register samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            fault_q     <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            // Grant and response in the same cycle leave the count unchanged.
            case ({grant, resp_accept})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect) begin
                // Everything still in flight now belongs to the old path; a
                // response arriving this cycle is consumed and discarded.
                drop_cnt   <= outstanding - CW'(resp_accept);
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fetch_pc   <= target;
                resp_pc    <= target;
                state      <= misaligned ? FAULT : RUN;
                fault_q    <= misaligned;
            end else begin
                if (resp_accept && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (grant) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + PC_STEP;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CW'(1);
                    2'b01:   fifo_count <= fifo_count - CW'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    // NOTE: FIFO storage has no reset; an entry is only ever read while
    // fifo_count marks it as holding a pushed word.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Self-checking bench for fetch_controller. A memory model answers requests in
// order with word_at(addr); a scoreboard queue holds the PCs decode should see
// next (sequential from the last reset/redirect). Directed scenarios cover fill,
// back-pressure, grant stalls, redirects with in-flight reads and the alignment
// check, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

    localparam int          AW    = 32;
    localparam int          IW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;
`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_target = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [IW-1:0] mem_rdata = '0;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic          fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    // memory model state
    logic [AW-1:0] pend_q[$];
    int            gnt_pct = 100;
    int            rv_pct  = 100;
    bit            straggler = 1'b0;

    // scoreboard state
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_next = '0;
    bit            exp_on = 1'b0;
    int            grant_cnt = 0;
    int            pop_cnt = 0;

    // monitor history
    bit            fault_model = 1'b0;
    bit            prev_hold = 1'b0;
    bit            prev_stall = 1'b0;
    bit            prev_redirect = 1'b0;
    logic [AW-1:0] hold_pc;
    logic [IW-1:0] hold_instr;
    logic [AW-1:0] stall_addr;

    fetch_controller #(
        .ADDRESS_WIDTH (AW),
        .INSTR_WIDTH   (IW),
        .FIFO_DEPTH    (DEPTH),
        .RESET_PC      (RPC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Instruction memory contents: a scrambled function of the address.
    function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void refill();
        while (exp_on && exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endfunction

    // Memory responder: grants with probability gnt_pct, returns queued reads
    // in order no earlier than the cycle after the grant.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = ($urandom_range(99) < gnt_pct);
            if (straggler) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
                straggler  = 1'b0;
            end else if (pend_q.size() > 0 && $urandom_range(99) < rv_pct) begin
                mem_rvalid = 1'b1;
                mem_rdata  = word_at(pend_q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (rst) begin
            fault_model   = 1'b0;
            prev_hold     = 1'b0;
            prev_stall    = 1'b0;
            prev_redirect = 1'b0;
        end else begin
            check("fetch_fault", fetch_fault, fault_model);
            if (fault_model) check("req_in_fault", mem_req, 1'b0);
            if (redirect) check("req_during_redirect", mem_req, 1'b0);
            if (prev_redirect) check("valid_after_redirect", instr_valid, 1'b0);
            if (mem_req) check("addr_align", mem_addr[1:0], 2'b00);
            check("inflight_bound", pend_q.size() <= DEPTH, 1'b1);
            if (prev_stall) check("addr_hold", mem_addr, stall_addr);
            if (prev_hold && !prev_redirect) begin
                check("head_valid_hold", instr_valid, 1'b1);
                check("head_pc_hold", instr_pc, hold_pc);
                check("head_instr_hold", instr, hold_instr);
            end

            if (instr_valid && instr_ready && !redirect) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_instr: got pc 0x%0h, expected no instruction", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instr_data", instr, word_at(e));
                    refill();
                end
            end

            if (mem_req && mem_gnt) begin
                grant_cnt++;
                pend_q.push_back(mem_addr);
            end
            if (redirect) fault_model = ALIGN && (redirect_target[1:0] != 2'b00);

            prev_redirect = redirect;
            prev_stall    = mem_req && !mem_gnt;
            stall_addr    = mem_addr;
            prev_hold     = instr_valid && !instr_ready;
            hold_pc       = instr_pc;
            hold_instr    = instr;
        end
    end

    // Reset, check idle outputs, release with one straggler response in the
    // first cycle. Returns just after the release edge.
    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        repeat (3) @(posedge clk);
        pend_q.delete();
        grant_cnt = 0;
        pop_cnt   = 0;
        exp_q.delete();
        exp_next = RPC;
        exp_on   = 1'b1;
        refill();
        @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_fetch_fault", fetch_fault, 1'b0);
        @(posedge clk);
        straggler = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // One-cycle redirect; returns rvalid as seen during the redirect cycle.
    task automatic redirect_to(input logic [AW-1:0] t, output logic rv_seen);
        @(posedge clk);
        #1;
        redirect        = 1'b1;
        redirect_target = t;
        exp_q.delete();
        exp_next = {t[AW-1:2], 2'b00};
        exp_on   = !(ALIGN && (t[1:0] != 2'b00));
        refill();
        @(negedge clk);
        rv_seen = mem_rvalid;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    task automatic wait_pop(input string name, input logic [AW-1:0] exp_pc);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(instr_valid && instr_ready) && k < 50);
        if (instr_valid && instr_ready) begin
            check(name, instr_pc, exp_pc);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timed out waiting for an instruction", name);
        end
    endtask

    initial begin
        logic [7:0]    vseq;
        logic          rv;
        logic [AW-1:0] t;
        int            k;

        #1;
        // Fill: gnt=1, 1-cycle memory, ready=1 -> valid from the third cycle on.
        instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vseq[i] = instr_valid;
        end
        check("fill_valid_seq", vseq, 8'hFC);

        // Back-pressure: ready=0 -> credit exhausted, head PC 0 held.
        instr_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        check("stall_mem_req", mem_req, 1'b0);
        check("stall_valid", instr_valid, 1'b1);
        check("stall_head_pc", instr_pc, 32'h0);
        check("stall_credit", 64'(grant_cnt - pop_cnt), 64'(DEPTH));

        // Grant withheld for 3 cycles: address parked at 0x10.
        gnt_pct = 0;
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mem_req && k < 20);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("gnt_low_req", mem_req, 1'b1);
            check("gnt_low_addr", mem_addr, 32'h10);
        end
        gnt_pct = 100;
        @(negedge clk);
        check("gnt_taken", mem_req && mem_gnt, 1'b1);
        check("gnt_taken_addr", mem_addr, 32'h10);
        @(negedge clk);
        check("pc_after_gnt", mem_addr, 32'h14);

        // Redirect with at least two reads in flight.
        rv_pct = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (pend_q.size() < 2 && k < 30);
        check("t4_inflight", pend_q.size() >= 2, 1'b1);
        rv_pct = 100;
        redirect_to(32'h100, rv);
        wait_pop("t4_first_pc", 32'h100);

        // Redirect colliding with an arriving response and a pop.
        repeat (6) @(negedge clk);
        redirect_to(32'h300, rv);
        check("t5_rvalid_at_redirect", rv, 1'b1);
        @(negedge clk);
        check("t5_fifo_empty", instr_valid, 1'b0);
        check("t5_mem_addr", mem_addr, 32'h300);
        check("t5_mem_req", mem_req, 1'b1);
        wait_pop("t5_first_pc", 32'h300);

        // Misaligned redirect.
        redirect_to(32'h102, rv);
`ifdef ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_fault", fetch_fault, 1'b1);
            check("t6_no_req", mem_req, 1'b0);
            check("t6_no_valid", instr_valid, 1'b0);
        end
        redirect_to(32'h200, rv);
        @(negedge clk);
        check("t6_fault_clear", fetch_fault, 1'b0);
        check("t6_addr", mem_addr, 32'h200);
        wait_pop("t6_first_pc", 32'h200);
`else
        @(negedge clk);
        check("t6_no_fault", fetch_fault, 1'b0);
        wait_pop("t6_first_pc", 32'h100);
`endif

        // Randomized traffic, redirects and one mid-run reset.
        for (int seg = 0; seg < 8; seg++) begin
            gnt_pct = $urandom_range(100, 30);
            rv_pct  = $urandom_range(100, 30);
            for (int c = 0; c < 50; c++) begin
                @(posedge clk);
                #1;
                instr_ready = ($urandom_range(99) < 70);
                if (seg == 4 && c == 25) begin
                    do_reset();
                end else if ($urandom_range(99) < 4) begin
                    t = $urandom & 32'h0000_0FFC;
                    if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(3));
                    redirect_to(t, rv);
                end
            end
        end

        // Leave any fault state and drain.
        redirect_to(32'h400, rv);
        gnt_pct     = 100;
        rv_pct      = 100;
        instr_ready = 1'b1;
        wait_pop("final_first_pc", 32'h400);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
